sc_dmem_arbiter: RTL and testbench

- Shares the single data-memory/I-O bus (dram plus memory-mapped hex/led/sw/key window) between the CPU data port and a DMA/loader port.
- Runs on dmem_clk.
- Grants one requester per transfer using a req/ack handshake, drives the shared bus, and returns read data.
- Blocks DMA from the I/O window and bounds DMA locked bursts so the CPU cannot starve.

---
 rtl/sc_dmem_arbiter_pkg.sv | 27 ++
 rtl/sc_dmem_arbiter_if.sv | 50 +++++
 rtl/sc_dmem_arbiter_sat_counter.sv | 28 ++
 rtl/sc_dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_sc_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sc_dmem_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, the
// I/O window address tag and the grant-id constants used to remember which
// requester was served last.
// ---------------------------------------------------------------------------
package sc_dmem_pkg;

    // Arbiter FSM states: each transfer is one address cycle (ACC) followed
    // by one completion cycle (ACK).
    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_ACK,
        DMA_ACC,
        DMA_ACK
    } arb_state_t;

    // Value of addr[31:8] that selects the memory-mapped hex/led/sw/key window.
    localparam logic [23:0] IO_HI = 24'hffffff;

    // Identity of the most recent grant holder.
    typedef logic grant_t;
    localparam grant_t GNT_CPU = 1'b0;
    localparam grant_t GNT_DMA = 1'b1;

endpackage

// File: rtl/sc_dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// sc_dmem_arbiter_if
// Bundles the CPU data port, the DMA/loader port and the shared memory bus.
//   slave  : arbiter side (takes requests and mem_rdata, drives acks and bus)
//   master : environment side (requesters plus the memory/I-O devices)
// Parameters: AW address width, DW data width.
// ---------------------------------------------------------------------------
interface sc_dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_lock;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic          dma_err;
    logic [DW-1:0] dma_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_err, dma_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_err, dma_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/sc_dmem_arbiter_sat_counter.sv
// ---------------------------------------------------------------------------
// sc_sat_counter
// Up-counter that sticks at all-ones instead of wrapping; cleared only by
// the asynchronous active-low reset.
// Ports: dmem_clk clock, resetn reset, inc count enable, count value.
// Parameter: W counter width.
// ---------------------------------------------------------------------------
module sc_sat_counter #(
    parameter int W = 16
) (
    input  logic         dmem_clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Count enabled cycles, holding once every bit is set.
    always_ff @(posedge dmem_clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// sc_dmem_arbiter
// Shares the data-memory / I-O bus between the CPU data port and a DMA
// port. One requester owns each two-cycle transfer (ACC then ACK). DMA is
// kept out of the I/O window (access suppressed, dma_err flagged) and its
// locked bursts are cut after LOCK_MAX beats so a waiting CPU gets in.
// Ports:
//   dmem_clk      clock
//   resetn        asynchronous active-low reset
//   bus           sc_dmem_arbiter_if.slave (CPU, DMA and shared bus signals)
//   cpu_wait_cnt  saturating count of cycles the CPU waited for an ack
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking;
// otherwise the CPU wins every tie.
// ---------------------------------------------------------------------------
import sc_dmem_pkg::*;

module sc_dmem_arbiter #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-9:0] IO_HI    = sc_dmem_pkg::IO_HI,
    parameter int            LOCK_MAX = 8,
    parameter int            WCNT_W   = 16
) (
    input  logic              dmem_clk,
    input  logic              resetn,
    sc_dmem_arbiter_if.slave  bus,
    output logic [WCNT_W-1:0] cpu_wait_cnt
);

    localparam int LC_W = $clog2(LOCK_MAX + 1);
    localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_MAX - 1);
    localparam logic [LC_W-1:0] LC_ONE    = {{(LC_W-1){1'b0}}, 1'b1};

    arb_state_t      state_q, state_d;
    grant_t          last_grant_q, last_grant_d;
    logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
    logic            dma_err_q;
    logic            io_hit;

    assign io_hit = (bus.dma_addr[AW-1:8] == IO_HI);

    // State, grant history, burst length and the latched I/O fault flag.
    always_ff @(posedge dmem_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DMA;
            lock_cnt_q   <= '0;
            dma_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            dma_err_q    <= (state_q == DMA_ACC) && io_hit;
        end
    end

    // Next-state logic. A forced burst release lands in IDLE with
    // last_grant=DMA, so either tie-break policy hands a waiting CPU the bus.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_cnt_d   = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req && bus.dma_req) begin
`ifdef DMEM_ARB_RR_EN
                    state_d = (last_grant_q == GNT_CPU) ? DMA_ACC : CPU_ACC;
`else
                    state_d = CPU_ACC;
`endif
                end else if (bus.cpu_req) begin
                    state_d = CPU_ACC;
                end else if (bus.dma_req) begin
                    state_d = DMA_ACC;
                end
            end
            CPU_ACC: state_d = CPU_ACK;
            CPU_ACK: state_d = IDLE;
            DMA_ACC: state_d = DMA_ACK;
            DMA_ACK: begin
                if (bus.dma_req && bus.dma_lock && (lock_cnt_q < LOCK_LAST)) begin
                    state_d    = DMA_ACC;
                    lock_cnt_d = lock_cnt_q + LC_ONE;
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == CPU_ACC) last_grant_d = GNT_CPU;
        if (state_d == DMA_ACC) last_grant_d = GNT_DMA;
    end

    // Bus and completion outputs decode straight from the state, so an
    // asynchronous reset drops mem_we and the acks immediately.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_rdata = '0;
        bus.dma_ack   = 1'b0;
        bus.dma_err   = 1'b0;
        bus.dma_rdata = '0;
        unique case (state_q)
            CPU_ACC: begin
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                bus.mem_we    = bus.cpu_we;
            end
            CPU_ACK: begin
                bus.cpu_ack   = 1'b1;
                bus.cpu_rdata = bus.mem_rdata;
            end
            DMA_ACC: begin
                if (!io_hit) begin
                    bus.mem_addr  = bus.dma_addr;
                    bus.mem_wdata = bus.dma_wdata;
                    bus.mem_we    = bus.dma_we;
                end
            end
            DMA_ACK: begin
                bus.dma_ack   = 1'b1;
                bus.dma_err   = dma_err_q;
                bus.dma_rdata = dma_err_q ? '0 : bus.mem_rdata;
            end
            default: ;
        endcase
    end

    sc_sat_counter #(.W(WCNT_W)) u_wait_cnt (
        .dmem_clk (dmem_clk),
        .resetn   (resetn),
        .inc      (bus.cpu_req && !bus.cpu_ack),
        .count    (cpu_wait_cnt)
    );

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sc_dmem_arbiter
// Directed bench for sc_dmem_arbiter. A second instance with WCNT_W=4
// mirrors the same inputs to exercise counter saturation.
// ---------------------------------------------------------------------------
import sc_dmem_pkg::*;

module tb_sc_dmem_arbiter;

    logic        dmem_clk = 1'b0;
    logic        resetn   = 1'b0;
    logic [15:0] wait16;
    logic [3:0]  wait4;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem_model [0:255];

    sc_dmem_arbiter_if #(.AW(32), .DW(32)) u_bus ();
    sc_dmem_arbiter_if #(.AW(32), .DW(32)) u_bus4 ();

    sc_dmem_arbiter #(.WCNT_W(16)) u_dut (
        .dmem_clk     (dmem_clk),
        .resetn       (resetn),
        .bus          (u_bus.slave),
        .cpu_wait_cnt (wait16)
    );

    sc_dmem_arbiter #(.WCNT_W(4)) u_dut4 (
        .dmem_clk     (dmem_clk),
        .resetn       (resetn),
        .bus          (u_bus4.slave),
        .cpu_wait_cnt (wait4)
    );

    assign u_bus4.cpu_req   = u_bus.cpu_req;
    assign u_bus4.cpu_we    = u_bus.cpu_we;
    assign u_bus4.cpu_addr  = u_bus.cpu_addr;
    assign u_bus4.cpu_wdata = u_bus.cpu_wdata;
    assign u_bus4.dma_req   = u_bus.dma_req;
    assign u_bus4.dma_lock  = u_bus.dma_lock;
    assign u_bus4.dma_we    = u_bus.dma_we;
    assign u_bus4.dma_addr  = u_bus.dma_addr;
    assign u_bus4.dma_wdata = u_bus.dma_wdata;
    assign u_bus4.mem_rdata = u_bus.mem_rdata;

    always #5 dmem_clk = ~dmem_clk;

    // Memory with one-cycle registered read, indexed by word address.
    always @(posedge dmem_clk) begin
        if (u_bus.mem_we) mem_model[u_bus.mem_addr[9:2]] <= u_bus.mem_wdata;
        u_bus.mem_rdata <= mem_model[u_bus.mem_addr[9:2]];
    end

    task automatic tick();
        @(posedge dmem_clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_bus.cpu_req   = 1'b0;
        u_bus.cpu_we    = 1'b0;
        u_bus.cpu_addr  = '0;
        u_bus.cpu_wdata = '0;
        u_bus.dma_req   = 1'b0;
        u_bus.dma_lock  = 1'b0;
        u_bus.dma_we    = 1'b0;
        u_bus.dma_addr  = '0;
        u_bus.dma_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Outputs and internal state while reset is held.
    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        checks++; if (u_bus.cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_ack: got %b want 0", u_bus.cpu_ack); end
        checks++; if (u_bus.dma_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_dma_ack: got %b want 0", u_bus.dma_ack); end
        checks++; if (u_bus.dma_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_dma_err: got %b want 0", u_bus.dma_err); end
        checks++; if (u_bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b want 0", u_bus.mem_we); end
        checks++; if (u_bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 0", u_bus.mem_addr); end
        checks++; if (wait16 !== 16'd0) begin errors++; $display("[TB] FAIL reset_wait_cnt: got %0d want 0", wait16); end
        checks++; if (u_dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d want IDLE", u_dut.state_q); end
        checks++; if (u_dut.last_grant_q !== GNT_DMA) begin errors++; $display("[TB] FAIL reset_last_grant: got %b want DMA", u_dut.last_grant_q); end
        resetn = 1'b1;
    endtask

    // CPU write then read of the same word.
    task automatic test_cpu_only();
        apply_reset();
        u_bus.cpu_req = 1'b1; u_bus.cpu_we = 1'b1;
        u_bus.cpu_addr = 32'h10; u_bus.cpu_wdata = 32'hDEADBEEF;
        tick();
        checks++; if (u_bus.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL cpu_wr_mem_we: got %b want 1", u_bus.mem_we); end
        checks++; if (u_bus.mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL cpu_wr_mem_addr: got %h want 10", u_bus.mem_addr); end
        checks++; if (u_bus.cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL cpu_wr_early_ack: got %b want 0", u_bus.cpu_ack); end
        tick();
        checks++; if (u_bus.cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL cpu_wr_ack: got %b want 1", u_bus.cpu_ack); end
        checks++; if (u_bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL cpu_wr_ack_mem_we: got %b want 0", u_bus.mem_we); end
        u_bus.cpu_req = 1'b0;
        tick();
        u_bus.cpu_req = 1'b1; u_bus.cpu_we = 1'b0; u_bus.cpu_wdata = 32'h0;
        tick();
        checks++; if (u_bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL cpu_rd_mem_we: got %b want 0", u_bus.mem_we); end
        tick();
        checks++; if (u_bus.cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL cpu_rd_ack: got %b want 1", u_bus.cpu_ack); end
        checks++; if (u_bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL cpu_rd_data: got %h want deadbeef", u_bus.cpu_rdata); end
        u_bus.cpu_req = 1'b0;
        tick();
    endtask

    // Simultaneous requests, then a second tie after the CPU is served.
    task automatic test_arbitration();
        apply_reset();
        u_bus.cpu_req = 1'b1; u_bus.cpu_addr = 32'h10;
        u_bus.dma_req = 1'b1; u_bus.dma_addr = 32'h20;
        tick();
        checks++; if (u_bus.mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL arb_first_grant: got %h want 10", u_bus.mem_addr); end
        tick();
        checks++; if (u_bus.cpu_ack !== 1'b1 || u_bus.dma_ack !== 1'b0) begin errors++; $display("[TB] FAIL arb_first_ack: got cpu=%b dma=%b want cpu=1 dma=0", u_bus.cpu_ack, u_bus.dma_ack); end
        u_bus.cpu_req = 1'b0;
        tick();
        u_bus.cpu_req = 1'b1;
        tick();
`ifdef DMEM_ARB_RR_EN
        checks++; if (u_bus.mem_addr !== 32'h20) begin errors++; $display("[TB] FAIL arb_second_grant: got %h want 20", u_bus.mem_addr); end
        tick();
        checks++; if (u_bus.dma_ack !== 1'b1 || u_bus.dma_rdata !== 32'hCAFE0020) begin errors++; $display("[TB] FAIL arb_dma_ack: got ack=%b data=%h want ack=1 data=cafe0020", u_bus.dma_ack, u_bus.dma_rdata); end
        u_bus.dma_req = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (u_bus.cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL arb_cpu_last: got %b want 1", u_bus.cpu_ack); end
        u_bus.cpu_req = 1'b0;
`else
        checks++; if (u_bus.mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL arb_second_grant: got %h want 10", u_bus.mem_addr); end
        tick();
        checks++; if (u_bus.cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL arb_cpu_again: got %b want 1", u_bus.cpu_ack); end
        u_bus.cpu_req = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (u_bus.dma_ack !== 1'b1 || u_bus.dma_rdata !== 32'hCAFE0020) begin errors++; $display("[TB] FAIL arb_dma_ack: got ack=%b data=%h want ack=1 data=cafe0020", u_bus.dma_ack, u_bus.dma_rdata); end
        u_bus.dma_req = 1'b0;
`endif
        tick();
    endtask

    // 12-beat locked DMA burst with the CPU waiting from cycle 3.
    task automatic test_lock_burst();
        int acks = 0;
        int acks_at_cpu = -1;
        int cpu_cyc = -1;
        int ninth_cyc = -1;
        apply_reset();
        u_bus.dma_req = 1'b1; u_bus.dma_lock = 1'b1; u_bus.dma_addr = 32'h40;
        u_bus.cpu_addr = 32'h10;
        for (int cyc = 1; cyc <= 60 && !(acks == 12 && cpu_cyc > 0); cyc++) begin
            tick();
            if (cyc == 3) u_bus.cpu_req = 1'b1;
            if (u_bus.dma_ack) begin
                acks++;
                if (acks == 9) ninth_cyc = cyc;
                if (acks == 12) begin u_bus.dma_req = 1'b0; u_bus.dma_lock = 1'b0; end
            end
            if (u_bus.cpu_ack) begin
                cpu_cyc = cyc;
                acks_at_cpu = acks;
                u_bus.cpu_req = 1'b0;
            end
        end
        checks++; if (acks_at_cpu !== 8) begin errors++; $display("[TB] FAIL burst_acks_before_cpu: got %0d want 8", acks_at_cpu); end
        checks++; if (cpu_cyc !== 19) begin errors++; $display("[TB] FAIL burst_cpu_ack_cycle: got %0d want 19", cpu_cyc); end
        checks++; if (ninth_cyc !== 22) begin errors++; $display("[TB] FAIL burst_resume_cycle: got %0d want 22", ninth_cyc); end
        checks++; if (acks !== 12) begin errors++; $display("[TB] FAIL burst_total_acks: got %0d want 12", acks); end
        checks++; if (wait16 !== 16'd16) begin errors++; $display("[TB] FAIL burst_wait_cnt: got %0d want 16", wait16); end
        tick();
    endtask

    // CPU waits 18 cycles behind a burst; the 4-bit counter sticks at 15.
    task automatic test_saturation();
        int cpu_cyc = -1;
        apply_reset();
        u_bus.dma_req = 1'b1; u_bus.dma_lock = 1'b1; u_bus.dma_addr = 32'h40;
        tick();
        u_bus.cpu_req = 1'b1;
        for (int cyc = 1; cyc <= 40 && cpu_cyc < 0; cyc++) begin
            if (cyc == 17) begin
                checks++; if (wait4 !== 4'd15) begin errors++; $display("[TB] FAIL sat_wait4_mid: got %0d want 15", wait4); end
            end
            if (u_bus.cpu_ack) begin cpu_cyc = cyc; u_bus.cpu_req = 1'b0; u_bus.dma_req = 1'b0; end
            else tick();
        end
        checks++; if (cpu_cyc < 0) begin errors++; $display("[TB] FAIL sat_cpu_timeout: got no ack want ack"); end
        checks++; if (wait4 !== 4'd15) begin errors++; $display("[TB] FAIL sat_wait4_end: got %0d want 15", wait4); end
        checks++; if (wait16 !== 16'd18) begin errors++; $display("[TB] FAIL sat_wait16_end: got %0d want 18", wait16); end
        u_bus.dma_lock = 1'b0;
        tick();
        tick();
    endtask

    // DMA write into the I/O window is blocked; CPU write passes through.
    task automatic test_io_fault();
        apply_reset();
        u_bus.dma_req = 1'b1; u_bus.dma_we = 1'b1;
        u_bus.dma_addr = 32'hFFFFFF60; u_bus.dma_wdata = 32'h12345678;
        tick();
        checks++; if (u_bus.mem_we !== 1'b0 || u_bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL io_dma_bus: got we=%b addr=%h want we=0 addr=0", u_bus.mem_we, u_bus.mem_addr); end
        tick();
        checks++; if (u_bus.dma_ack !== 1'b1 || u_bus.dma_err !== 1'b1 || u_bus.dma_rdata !== 32'h0) begin errors++; $display("[TB] FAIL io_dma_ack: got ack=%b err=%b data=%h want 1 1 0", u_bus.dma_ack, u_bus.dma_err, u_bus.dma_rdata); end
        u_bus.dma_req = 1'b0; u_bus.dma_we = 1'b0;
        tick();
        u_bus.cpu_req = 1'b1; u_bus.cpu_we = 1'b1;
        u_bus.cpu_addr = 32'hFFFFFF60; u_bus.cpu_wdata = 32'h0000ABCD;
        tick();
        checks++; if (u_bus.mem_we !== 1'b1 || u_bus.mem_addr !== 32'hFFFFFF60) begin errors++; $display("[TB] FAIL io_cpu_bus: got we=%b addr=%h want we=1 addr=ffffff60", u_bus.mem_we, u_bus.mem_addr); end
        tick();
        u_bus.cpu_req = 1'b0; u_bus.cpu_we = 1'b0;
        tick();
        u_bus.dma_req = 1'b1; u_bus.dma_addr = 32'h20;
        tick();
        tick();
        checks++; if (u_bus.dma_err !== 1'b0 || u_bus.dma_rdata !== 32'hCAFE0020) begin errors++; $display("[TB] FAIL io_dma_normal: got err=%b data=%h want 0 cafe0020", u_bus.dma_err, u_bus.dma_rdata); end
        u_bus.dma_req = 1'b0;
        tick();
    endtask

    // Reset asserted during a DMA write address cycle.
    task automatic test_reset_mid();
        apply_reset();
        u_bus.dma_req = 1'b1; u_bus.dma_lock = 1'b1; u_bus.dma_we = 1'b1;
        u_bus.dma_addr = 32'h80; u_bus.dma_wdata = 32'h55AA55AA;
        tick();
        tick();
        u_bus.cpu_req = 1'b1; u_bus.cpu_addr = 32'h10;
        tick();
        checks++; if (u_bus.mem_we !== 1'b1 || wait16 !== 16'd1) begin errors++; $display("[TB] FAIL rstmid_pre: got we=%b wait=%0d want we=1 wait=1", u_bus.mem_we, wait16); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (u_bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_mem_we: got %b want 0", u_bus.mem_we); end
        checks++; if (u_dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL rstmid_state: got %0d want IDLE", u_dut.state_q); end
        checks++; if (wait16 !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_wait_cnt: got %0d want 0", wait16); end
        idle_inputs();
        tick();
        checks++; if (u_bus.dma_ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_dma_ack: got %b want 0", u_bus.dma_ack); end
        resetn = 1'b1;
        tick();
        checks++; if (u_bus.dma_ack !== 1'b0 || u_dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL rstmid_after: got ack=%b state=%0d want ack=0 IDLE", u_bus.dma_ack, u_dut.state_q); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        mem_model[8] = 32'hCAFE0020;
        idle_inputs();
        $display("[TB] start");
        test_reset();
        test_cpu_only();
        test_arbitration();
        test_lock_burst();
        test_saturation();
        test_io_fault();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
